// File: rtl/de_write_arbiter_if.sv
// Write-request bundle between two requesters and the DESwitch bank arbiter.
// The arbiter takes the slave side; the master side drives requests and sees the bank drive.
interface de_write_arbiter_if #(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 1
);
  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic [NREG-1:0]  E;
  logic [WIDTH-1:0] D;
  logic             ack0;
  logic             ack1;
  logic             err;
  logic             busy;

  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  E, D, ack0, ack1, err, busy
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output E, D, ack0, ack1, err, busy
  );
endinterface

// File: rtl/de_write_arbiter.sv
// Round-robin arbiter granting one of two requesters a write per cycle into a
// bank of NREG DESwitch registers through a registered one-hot E and shared D.
module de_write_arbiter #(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 1
) (
  input logic               clk,
  input logic               reset,
  de_write_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR0  = 2'd1;
  localparam logic [1:0] WR1  = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic [NREG-1:0]  onehot;
  logic             in_range;

  // A requester whose write is currently on the bus is held off for one edge,
  // giving it time to see its ack and drop the level request.
  always_comb begin
    elig0    = bus.req0 && (state != WR0);
    elig1    = bus.req1 && (state != WR1);
    grant0   = elig0 && (!elig1 || !ptr);
    grant1   = elig1 && !grant0;
    grant    = grant0 || grant1;
    win_addr = grant1 ? bus.addr1 : bus.addr0;
    win_data = grant1 ? bus.data1 : bus.data0;
    onehot   = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = (win_addr == AW'(i));
    end
    in_range = |onehot;
  end

  // An address past the bank decodes to no enable bit; it is still acked,
  // flagged with err, and nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      bus.E    <= '0;
      bus.D    <= '0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err  <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state    <= grant0 ? WR0 : (grant1 ? WR1 : IDLE);
      if (grant) begin
        ptr <= grant0;
      end
      bus.E    <= grant ? onehot : '0;
      bus.D    <= (grant && in_range) ? win_data : '0;
      bus.ack0 <= grant0;
      bus.ack1 <= grant1;
      bus.err  <= grant && !in_range;
      bus.busy <= grant;
    end
  end

endmodule
